// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    // Wide enough for the largest supported digit count; sliced to NDIG at use.
    localparam logic [7:0] DIG_OFF = 8'h00;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer-side value/load handshake and the scanner's decoder and digit-driver outputs.
// master = value producer / display side, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                enable;
    logic                load;
    logic [4*NDIG-1:0]   bcd_in;
    logic                ld_ack;
    logic [3:0]          dec_bcd;
    logic [NDIG-1:0]     dig_sel;
    logic                frame_tick;
    logic                bcd_err;

    modport master (
        output enable, load, bcd_in,
        input  ld_ack, dec_bcd, dig_sel, frame_tick, bcd_err
    );

    modport slave (
        input  enable, load, bcd_in,
        output ld_ack, dec_bcd, dig_sel, frame_tick, bcd_err
    );
endinterface

// File: rtl/seg_dwell_timer.sv
// Dwell down-counter: load_i arms DWELL cycles, clr_i parks it at zero; no backpressure.
// done_o is high while the count is zero, i.e. in the last cycle of an armed dwell.
module seg_dwell_timer #(
    parameter int DWELL = 1000,
    parameter int CW    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic clr_i,
    output logic done_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CW'(DWELL - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Shared-decoder 7-seg scanner, registered outputs; define SEG_SCAN_LZB_EN for leading-zero blanking.
// ld_ack one cycle after capture; load is held by the requester until ld_ack (captured only in IDLE or frame-end BLANK).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DWELL = 1000,
    parameter int CW    = 16
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);
    localparam int IW = $clog2(NDIG);
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [3:0]        dec_q, dec_d;
    logic [NDIG-1:0]   dig_q, dig_d;
    logic              ack_q, ack_d;
    logic              tick_q, tick_d;
    logic              err_q, err_d;
    logic              tmr_load, tmr_clr, tmr_done;
    logic              frame_end, capture, enter_scan;
    logic [3:0]        nib;
    logic [NDIG-1:0]   blank_m;

`ifdef SEG_SCAN_LZB_EN
    function automatic logic [NDIG-1:0] lead_zero_mask(input logic [4*NDIG-1:0] v);
        logic [NDIG-1:0] m;
        logic            run;
        m   = '0;
        run = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            run  = run && (v[4*i +: 4] == 4'd0);
            m[i] = run;
        end
        return m;
    endfunction
`endif

    seg_dwell_timer #(.DWELL(DWELL), .CW(CW)) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .load_i (tmr_load),
        .clr_i  (tmr_clr),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        dec_d      = dec_q;
        dig_d      = dig_q;
        ack_d      = 1'b0;
        tick_d     = 1'b0;
        err_d      = err_q;
        tmr_load   = 1'b0;
        tmr_clr    = 1'b0;
        enter_scan = 1'b0;
        blank_m    = '0;

        // Captures land only between frames so a frame never mixes old and new digits.
        frame_end = (state_q == BLANK) && (idx_q == LAST);
        capture   = bus.load && ((state_q == IDLE) || frame_end);
        if (capture) begin
            shadow_d = bus.bcd_in;
            ack_d    = 1'b1;
        end

        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
            dig_d   = DIG_OFF[NDIG-1:0];
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    enter_scan = 1'b1;
                end
                SCAN: begin
                    if (tmr_done) begin
                        state_d = BLANK;
                        dig_d   = DIG_OFF[NDIG-1:0];
                        tick_d  = (idx_q == LAST);
                    end
                end
                BLANK: begin
                    state_d    = SCAN;
                    idx_d      = (idx_q == LAST) ? '0 : idx_q + IW'(1);
                    enter_scan = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    dig_d   = DIG_OFF[NDIG-1:0];
                end
            endcase
        end

`ifdef SEG_SCAN_LZB_EN
        blank_m = lead_zero_mask(shadow_d);
`endif
        nib = shadow_d[{idx_d, 2'b00} +: 4];
        if (enter_scan) begin
            tmr_load = 1'b1;
            dec_d    = nib;
            if (nib > BCD_MAX) begin
                dig_d = DIG_OFF[NDIG-1:0];
                err_d = 1'b1;
            end else if (blank_m[idx_d]) begin
                dig_d = DIG_OFF[NDIG-1:0];
            end else begin
                dig_d = NDIG'(1) << idx_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            dec_q    <= '0;
            dig_q    <= '0;
            ack_q    <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            dec_q    <= dec_d;
            dig_q    <= dig_d;
            ack_q    <= ack_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign bus.ld_ack     = ack_q;
    assign bus.dec_bcd    = dec_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_tick = tick_q;
    assign bus.bcd_err    = err_q;
endmodule
